// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave bridge: decodes MCU write frames into a paced register-write word,
// and shifts a status word back. All logic runs on clk; the SPI pins are synchronized.
module spi_reg_bridge #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic [11:0] wr_reg,
    output logic [3:0]  wr_reg_addr,
    output logic        wr_reg_changed,
    input  logic [31:0] status_reg,
    output logic        overrun,
    output logic [1:0]  fsm_state
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CMD   = 2'd1;
    localparam logic [1:0] WDATA = 2'd2;
    localparam logic [1:0] RDATA = 2'd3;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic sck_prev, cs_prev;
    logic sck_s, cs_s, mosi_s, sck_rise, sck_fall, cs_rise, cs_fall;

    logic [1:0]  state;
    logic [4:0]  bit_cnt;
    logic [6:0]  cmd_sr;
    logic [10:0] data_sr;
    logic [3:0]  addr;
    logic        latch_req;
    logic        word_valid;
    logic [15:0] word;

    logic [31:0] rd_sr, rd_src;
    logic        rd_first;

    logic [HW-1:0] hold_cnt;
    logic          pend_valid;
    logic [15:0]   pend_word;
    logic          commit_now;
    logic [15:0]   commit_word;
    logic          ovr_set, ovr_clr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sck_prev  <= sck_s;
            cs_prev   <= cs_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign cs_rise  = cs_s & ~cs_prev;
    assign cs_fall  = ~cs_s & cs_prev;

    assign spi_miso_oe = ~cs_s;
    assign fsm_state   = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            cmd_sr     <= '0;
            data_sr    <= '0;
            addr       <= '0;
            latch_req  <= 1'b0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            latch_req  <= 1'b0;
            word_valid <= 1'b0;
            if (cs_rise) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (cs_fall) begin
                        state   <= CMD;
                        bit_cnt <= '0;
                    end
                    CMD: if (sck_rise) begin
                        cmd_sr  <= {cmd_sr[5:0], mosi_s};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            addr    <= {cmd_sr[2:0], mosi_s};
                            bit_cnt <= '0;
                            if (cmd_sr[6]) begin
                                state <= WDATA;
                            end else begin
                                state     <= RDATA;
                                latch_req <= 1'b1;
                            end
                        end
                    end
                    // Bits past the 16th are ignored until cs_n rises.
                    WDATA: if (sck_rise && bit_cnt < 5'd16) begin
                        data_sr <= {data_sr[9:0], mosi_s};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd15) begin
                            word_valid <= 1'b1;
                            word       <= {addr, data_sr, mosi_s};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_src = 32'd0;
        if (addr == 4'h0)      rd_src = status_reg;
        else if (addr == 4'hF) rd_src = {31'd0, overrun};
    end

    // The latch presents bit 31 immediately, so the sck fall that ends the cmd byte is skipped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spi_miso <= 1'b0;
            rd_sr    <= '0;
            rd_first <= 1'b0;
        end else if (cs_s) begin
            spi_miso <= 1'b0;
            rd_first <= 1'b0;
        end else if (latch_req) begin
            spi_miso <= rd_src[31];
            rd_sr    <= {rd_src[30:0], 1'b0};
            rd_first <= 1'b1;
        end else if (state != RDATA) begin
            spi_miso <= 1'b0;
        end else if (sck_fall) begin
            if (rd_first) begin
                rd_first <= 1'b0;
            end else begin
                spi_miso <= rd_sr[31];
                rd_sr    <= {rd_sr[30:0], 1'b0};
            end
        end
    end

    always_comb begin
        commit_now  = 1'b0;
        commit_word = pend_word;
        if (hold_cnt == '0) begin
            if (pend_valid) begin
                commit_now = 1'b1;
            end else if (word_valid) begin
                commit_now  = 1'b1;
                commit_word = word;
            end
        end
    end

    assign ovr_set = word_valid && (hold_cnt != '0) && pend_valid;
    assign ovr_clr = latch_req && (addr == 4'hF);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_reg         <= '0;
            wr_reg_addr    <= '0;
            wr_reg_changed <= 1'b0;
            hold_cnt       <= '0;
            pend_valid     <= 1'b0;
            pend_word      <= '0;
            overrun        <= 1'b0;
        end else begin
            if (commit_now) begin
                wr_reg         <= commit_word[11:0];
                wr_reg_addr    <= commit_word[15:12];
                wr_reg_changed <= ~wr_reg_changed;
                hold_cnt       <= HOLD_RELOAD;
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
            // A new word buffers unless it commits directly this cycle.
            if (word_valid && !((hold_cnt == '0) && !pend_valid)) begin
                pend_valid <= 1'b1;
                pend_word  <= word;
            end else if (commit_now) begin
                pend_valid <= 1'b0;
            end
            if (ovr_set)      overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: drives SPI frames bit by bit and checks committed words
// against an expected queue, plus read-back data, pacing and reset behaviour.
module tb_spi_reg_bridge;
    localparam int HOLD = 800;
    localparam int HALF = 5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_sck = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso, spi_miso_oe;
    logic [11:0] wr_reg;
    logic [3:0]  wr_reg_addr;
    logic        wr_reg_changed;
    logic [31:0] status_reg = 32'd0;
    logic        overrun;
    logic [1:0]  fsm_state;

    spi_reg_bridge #(.SYNC_STAGES(2), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset_n(reset_n), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .wr_reg(wr_reg), .wr_reg_addr(wr_reg_addr), .wr_reg_changed(wr_reg_changed),
        .status_reg(status_reg), .overrun(overrun), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad = 0;
    longint cyc = 0;
    always @(posedge clk) cyc++;

    logic [15:0] exp_q[$];
    int          tog_cnt = 0;
    longint      tog_last = 0, tog_prev = 0;
    logic        prev_chg = 1'b0;
    logic [15:0] last_word = 16'd0;
    int          stab_err = 0;

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] data;
        logic [15:0] exp_word;
    } wr_vec_t;

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] status;
        logic [31:0] exp_data;
    } rd_vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every wr_reg_changed toggle pops one expected {addr,data} word.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_chg  = 1'b0;
            last_word = 16'd0;
        end else if (wr_reg_changed !== prev_chg) begin
            prev_chg = wr_reg_changed;
            tog_cnt++;
            tog_prev = tog_last;
            tog_last = cyc;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_toggle got=%h want=none", {wr_reg_addr, wr_reg});
            end else begin
                check("toggle_word", {16'd0, wr_reg_addr, wr_reg}, {16'd0, exp_q.pop_front()});
            end
            last_word = {wr_reg_addr, wr_reg};
        end else if ({wr_reg_addr, wr_reg} !== last_word) begin
            stab_err++;
        end
    end

    task automatic spi_frame(input logic [7:0] cmd, input logic [15:0] wdata, input int nbits,
                             output logic [31:0] rdata, output logic [7:0] tail);
        rdata = 32'd0;
        tail  = 8'd0;
        spi_cs_n = 1'b0;
        tick(HALF * 2);
        for (int i = 0; i < nbits; i++) begin
            if (i < 8)       spi_mosi = cmd[7-i];
            else if (i < 24) spi_mosi = wdata[23-i];
            else             spi_mosi = 1'b0;
            tick(HALF);
            if (i >= 8 && i < 40) rdata = {rdata[30:0], spi_miso};
            else if (i >= 40)     tail = {tail[6:0], spi_miso};
            spi_sck = 1'b1;
            tick(HALF);
            spi_sck = 1'b0;
        end
        tick(HALF * 2);
        spi_cs_n = 1'b1;
        tick(HALF * 4);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check({"drain_", name}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_vec_t     wv[2];
        rd_vec_t     rv[5];
        logic [31:0] rdata;
        logic [7:0]  tail;
        int          tog0;

        wv[0] = '{8'h82, 16'h0A5C, 16'h2A5C};
        wv[1] = '{8'hC9, 16'hB123, 16'h9123};
        rv[0] = '{8'h0F, 32'h0000_0000, 32'h0000_0001};
        rv[1] = '{8'h0F, 32'hFFFF_FFFF, 32'h0000_0000};
        rv[2] = '{8'h00, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        rv[3] = '{8'h75, 32'hFFFF_FFFF, 32'h0000_0000};
        rv[4] = '{8'h70, 32'hA5A5_0F0F, 32'hA5A5_0F0F};

        tick(5);
        check("rst_miso", spi_miso, 0);
        check("rst_miso_oe", spi_miso_oe, 0);
        check("rst_wr_reg", wr_reg, 0);
        check("rst_wr_reg_addr", wr_reg_addr, 0);
        check("rst_changed", wr_reg_changed, 0);
        check("rst_overrun", overrun, 0);
        check("rst_fsm", fsm_state, 0);
        reset_n = 1'b1;
        tick(5);

        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(wv[i].exp_word);
            spi_frame(wv[i].cmd, wv[i].data, 24, rdata, tail);
            wait_drain("single_write", 100);
            check("single_wr_reg", wr_reg, wv[i].exp_word[11:0]);
            check("single_wr_addr", wr_reg_addr, wv[i].exp_word[15:12]);
            tick(HOLD + 20);
        end

        exp_q.push_back(16'h0123);
        exp_q.push_back(16'h100F);
        spi_frame(8'h80, 16'h0123, 24, rdata, tail);
        spi_frame(8'h81, 16'h000F, 24, rdata, tail);
        wait_drain("back_to_back", 3 * HOLD);
        check("hold_gap", 32'(tog_last - tog_prev), HOLD);
        tick(HOLD + 20);

        exp_q.push_back(16'h5111);
        exp_q.push_back(16'h7333);
        spi_frame(8'h85, 16'h0111, 24, rdata, tail);
        spi_frame(8'h86, 16'h0222, 24, rdata, tail);
        spi_frame(8'h87, 16'h0333, 24, rdata, tail);
        wait_drain("triple_write", 3 * HOLD);
        check("overrun_set", overrun, 1);

        for (int i = 0; i < 5; i++) begin
            status_reg = rv[i].status;
            spi_frame(rv[i].cmd, 16'd0, 44, rdata, tail);
            check("read_data", rdata, rv[i].exp_data);
            check("read_tail_zero", {24'd0, tail}, 0);
        end
        check("overrun_cleared", overrun, 0);

        status_reg = 32'hDEAD_BEEF;
        fork
            spi_frame(8'h00, 16'd0, 40, rdata, tail);
            begin
                tick(150);
                status_reg = 32'h1234_5678;
            end
        join
        check("read_status_midframe", rdata, 32'hDEAD_BEEF);
        check("miso_oe_idle", spi_miso_oe, 0);

        tick(HOLD + 20);
        tog0 = tog_cnt;
        spi_frame(8'h83, 16'h0FFF, 12, rdata, tail);
        exp_q.push_back(16'h37FF);
        spi_frame(8'h83, 16'h07FF, 24, rdata, tail);
        wait_drain("after_abort", 100);
        tick(HOLD + 20);
        check("abort_toggles", tog_cnt - tog0, 1);
        check("abort_wr_reg", wr_reg, 12'h7FF);
        check("abort_wr_addr", wr_reg_addr, 4'h3);

        exp_q.push_back(16'h4AAA);
        spi_frame(8'h84, 16'h0AAA, 24, rdata, tail);
        wait_drain("pre_reset", 100);
        spi_frame(8'h85, 16'h0555, 24, rdata, tail);
        tick(10);
        reset_n = 1'b0;
        tick(2);
        check("mid_rst_miso", spi_miso, 0);
        check("mid_rst_miso_oe", spi_miso_oe, 0);
        check("mid_rst_wr_reg", wr_reg, 0);
        check("mid_rst_wr_addr", wr_reg_addr, 0);
        check("mid_rst_changed", wr_reg_changed, 0);
        check("mid_rst_overrun", overrun, 0);
        reset_n = 1'b1;
        tog0 = tog_cnt;
        tick(2 * HOLD);
        check("post_rst_no_toggle", tog_cnt - tog0, 0);
        check("post_rst_wr_reg", wr_reg, 0);

        check("stable_between_toggles", stab_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
